// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of every signal between the memory arbiter, its two
// requesters (fetch and MEM stages), the byte-wide RAM and the stall controller.
//   rdy                         global ready, low freezes transfers
//   if_req_i / if_addr_i        fetch request and word address
//   if_data_o / if_done_o       fetched word and its one-cycle done pulse
//   mem_req_i / mem_we_i        data request, store (1) or load (0)
//   mem_len_i / mem_addr_i      byte count minus one, data address
//   mem_wdata_i                 store data, low byte first
//   mem_rdata_o / mem_done_o    load data and its one-cycle done pulse
//   ram_din_i                   RAM read byte, one cycle after its address
//   ram_dout_o / ram_a_o        RAM write byte, RAM byte address
//   ram_wr_o                    RAM write enable
//   if_stall_req_o / mem_stall_req_o  stall requests to the pipeline
// Modport master is the requester/RAM side, modport slave is the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              rdy;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [31:0]       if_data_o;
  logic              if_done_o;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_len_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic [31:0]       mem_rdata_o;
  logic              mem_done_o;
  logic [7:0]        ram_din_i;
  logic [7:0]        ram_dout_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic              ram_wr_o;
  logic              if_stall_req_o;
  logic              mem_stall_req_o;

  modport master (
    output rdy, if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i,
           mem_addr_i, mem_wdata_i, ram_din_i,
    input  if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_dout_o,
           ram_a_o, ram_wr_o, if_stall_req_o, mem_stall_req_o
  );

  modport slave (
    input  rdy, if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i,
           mem_addr_i, mem_wdata_i, ram_din_i,
    output if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_dout_o,
           ram_a_o, ram_wr_o, if_stall_req_o, mem_stall_req_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one byte-wide RAM port between instruction fetch and
// the MEM stage. Word, halfword and byte accesses are split into little-endian
// byte transfers; MEM wins over IF, and an accepted transfer runs to completion.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   mem_arbiter_if.slave, all request, response, RAM and stall signals
// The RAM port (address, write enable, write byte) is decoded from registered
// state and gated by rdy, so a rdy-low cycle never issues or writes anything.
// Done pulses and assembled read data are registered.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   base;
  logic [2:0]          n;        // bytes in the transfer, 1..4
  logic [2:0]          icnt;     // bytes issued (reads) or written (stores)
  logic [2:0]          rcnt;     // bytes received
  logic [31:0]         wdata;
  logic [RAM_LAT-1:0]  inflight; // read issued RAM_LAT cycles ago, data on ram_din_i now
  logic [31:0]         if_data;
  logic [31:0]         mem_rdata;
  logic                if_done;
  logic                mem_done;

  logic                reading;
  logic                issue;
  logic                capture;
  logic                write;
  logic [2:0]          n_acc;

  // NOTE: every signal assigned in always_comb gets a value on all paths
  // (defaults first), otherwise synthesis infers latches.
  always_comb begin
    reading = (state == IF_RD) || (state == MEM_RD);
    issue   = reading && bus.rdy && (icnt < n);
    capture = reading && bus.rdy && inflight[RAM_LAT-1];
    write   = (state == MEM_WR) && bus.rdy && (icnt < n);
    n_acc   = 3'd4;
    case (bus.mem_len_i)
      2'd0:    n_acc = 3'd1;
      2'd1:    n_acc = 3'd2;
      default: n_acc = 3'd4;  // 2 is illegal and behaves as a word
    endcase
  end

  // Address arithmetic wraps naturally at the top of the address space.
  assign bus.ram_a_o    = (issue || write) ? base + ADDR_W'(icnt) : '0;
  assign bus.ram_wr_o   = write;
  assign bus.ram_dout_o = write ? wdata[{icnt[1:0], 3'b000} +: 8] : 8'h00;

  assign bus.if_data_o   = if_data;
  assign bus.if_done_o   = if_done;
  assign bus.mem_rdata_o = mem_rdata;
  assign bus.mem_done_o  = mem_done;

  assign bus.if_stall_req_o  = bus.if_req_i  && !if_done;
  assign bus.mem_stall_req_o = bus.mem_req_i && !mem_done;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      n         <= '0;
      icnt      <= '0;
      rcnt      <= '0;
      wdata     <= '0;
      inflight  <= '0;
      if_data   <= '0;
      mem_rdata <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          // A held request must not be re-accepted in its own done cycle.
          if (bus.rdy && !if_done && !mem_done) begin
            icnt     <= '0;
            rcnt     <= '0;
            inflight <= '0;
            if (bus.mem_req_i) begin
              base      <= bus.mem_addr_i;
              n         <= n_acc;
              wdata     <= bus.mem_wdata_i;
              mem_rdata <= '0;
              state     <= bus.mem_we_i ? MEM_WR : MEM_RD;
            end else if (bus.if_req_i) begin
              base    <= bus.if_addr_i;
              n       <= 3'd4;
              if_data <= '0;
              state   <= IF_RD;
            end
          end
        end

        IF_RD, MEM_RD: begin
          if (!bus.rdy) begin
            // Bytes in flight are dropped and reissued once rdy returns.
            inflight <= '0;
            icnt     <= rcnt;
          end else begin
            inflight <= (inflight << 1) | RAM_LAT'(issue);
            if (issue) icnt <= icnt + 3'd1;
            if (capture) begin
              if (state == IF_RD) if_data[{rcnt[1:0], 3'b000} +: 8] <= bus.ram_din_i;
              else                mem_rdata[{rcnt[1:0], 3'b000} +: 8] <= bus.ram_din_i;
              rcnt <= rcnt + 3'd1;
              if (rcnt + 3'd1 == n) begin
                state <= IDLE;
                if (state == IF_RD) if_done  <= 1'b1;
                else                mem_done <= 1'b1;
              end
            end
          end
        end

        MEM_WR: begin
          if (write) begin
            icnt <= icnt + 3'd1;
            if (icnt + 3'd1 == n) begin
              state    <= IDLE;
              mem_done <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed bench for mem_arbiter. A byte RAM model with one
// cycle read latency answers the RAM port. Cycle 0 of each scenario is the
// cycle a request is first presented in IDLE; outputs are sampled on the
// falling edge, inputs change 1 ns after the rising edge.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .RAM_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] ram [0:65535];
  int         wr_count = 0;
  int         n_checks = 0;
  int         n_pass   = 0;

  // RAM model: read data appears one cycle after the address; writes are
  // only counted, the contents are checked on the bus as they happen.
  always @(posedge clk) begin
    bus.ram_din_i <= ram[bus.ram_a_o[15:0]];
    if (bus.ram_wr_o) wr_count <= wr_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Word fetch of 0x1000 holding 13 05 00 00.
  task automatic run_fetch(input string tag);
    logic [31:0] ea;
    bus.if_addr_i = 32'h1000;
    for (int c = 0; c <= 7; c++) begin
      bus.if_req_i = (c <= 6);
      @(negedge clk);
      ea = (c >= 1 && c <= 4) ? 32'h1000 + 32'(c - 1) : 32'h0;
      check($sformatf("%s ram_a c%0d", tag, c), bus.ram_a_o, ea);
      check($sformatf("%s ram_wr c%0d", tag, c), 32'(bus.ram_wr_o), 32'h0);
      check($sformatf("%s if_done c%0d", tag, c), 32'(bus.if_done_o), 32'(c == 6));
      check($sformatf("%s if_stall c%0d", tag, c), 32'(bus.if_stall_req_o), 32'(c <= 5));
      if (c == 6) check($sformatf("%s if_data", tag), bus.if_data_o, 32'h0000_0513);
      next();
    end
  endtask

  initial begin
    logic [31:0] ea;
    logic [31:0] wd;
    int          w0;

    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05;
    ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
    ram[16'h3001] = 8'h80;
    ram[16'hFFFE] = 8'h11; ram[16'hFFFF] = 8'h22;
    ram[16'h0000] = 8'h33; ram[16'h0001] = 8'h44;

    rst             = 1'b1;
    bus.rdy         = 1'b1;
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.mem_req_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_len_i   = 2'd0;
    bus.mem_addr_i  = '0;
    bus.mem_wdata_i = '0;
    next();
    next();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst ram_a", bus.ram_a_o, 32'h0);
    check("rst ram_wr", 32'(bus.ram_wr_o), 32'h0);
    check("rst ram_dout", 32'(bus.ram_dout_o), 32'h0);
    check("rst if_data", bus.if_data_o, 32'h0);
    check("rst mem_rdata", bus.mem_rdata_o, 32'h0);
    check("rst if_done", 32'(bus.if_done_o), 32'h0);
    check("rst mem_done", 32'(bus.mem_done_o), 32'h0);
    next();

    // IF-only word fetch
    run_fetch("fetch");

    // Store word 0xDEADBEEF at 0x2000
    w0 = wr_count;
    wd = 32'hDEAD_BEEF;
    bus.mem_addr_i = 32'h2000; bus.mem_wdata_i = wd;
    bus.mem_we_i = 1'b1; bus.mem_len_i = 2'd3;
    for (int c = 0; c <= 6; c++) begin
      bus.mem_req_i = (c <= 5);
      @(negedge clk);
      ea = (c >= 1 && c <= 4) ? 32'h2000 + 32'(c - 1) : 32'h0;
      check($sformatf("st ram_wr c%0d", c), 32'(bus.ram_wr_o), 32'(c >= 1 && c <= 4));
      check($sformatf("st ram_a c%0d", c), bus.ram_a_o, ea);
      check($sformatf("st ram_dout c%0d", c), 32'(bus.ram_dout_o),
            (c >= 1 && c <= 4) ? ((wd >> (8 * (c - 1))) & 32'hFF) : 32'h0);
      check($sformatf("st mem_done c%0d", c), 32'(bus.mem_done_o), 32'(c == 5));
      check($sformatf("st mem_stall c%0d", c), 32'(bus.mem_stall_req_o), 32'(c <= 4));
      next();
    end
    check("st write count", 32'(wr_count - w0), 32'd4);

    // Load byte at 0x3001
    bus.mem_we_i = 1'b0; bus.mem_len_i = 2'd0; bus.mem_addr_i = 32'h3001;
    for (int c = 0; c <= 4; c++) begin
      bus.mem_req_i = (c <= 3);
      @(negedge clk);
      check($sformatf("ldb ram_a c%0d", c), bus.ram_a_o, (c == 1) ? 32'h3001 : 32'h0);
      check($sformatf("ldb mem_done c%0d", c), 32'(bus.mem_done_o), 32'(c == 3));
      if (c == 3) check("ldb rdata", bus.mem_rdata_o, 32'h0000_0080);
      next();
    end

    // Load half at 0x3000
    ram[16'h3000] = 8'h34; ram[16'h3001] = 8'h12;
    bus.mem_len_i = 2'd1; bus.mem_addr_i = 32'h3000;
    for (int c = 0; c <= 5; c++) begin
      bus.mem_req_i = (c <= 4);
      @(negedge clk);
      ea = (c == 1) ? 32'h3000 : (c == 2) ? 32'h3001 : 32'h0;
      check($sformatf("ldh ram_a c%0d", c), bus.ram_a_o, ea);
      check($sformatf("ldh mem_done c%0d", c), 32'(bus.mem_done_o), 32'(c == 4));
      if (c == 4) check("ldh rdata", bus.mem_rdata_o, 32'h0000_1234);
      next();
    end

    // Length code 2 loads a word; address wraps past 0xFFFFFFFF
    bus.mem_len_i = 2'd2; bus.mem_addr_i = 32'hFFFF_FFFE;
    for (int c = 0; c <= 7; c++) begin
      bus.mem_req_i = (c <= 6);
      @(negedge clk);
      ea = (c >= 1 && c <= 4) ? 32'hFFFF_FFFE + 32'(c - 1) : 32'h0;
      check($sformatf("ldw ram_a c%0d", c), bus.ram_a_o, ea);
      check($sformatf("ldw mem_done c%0d", c), 32'(bus.mem_done_o), 32'(c == 6));
      if (c == 6) check("ldw rdata", bus.mem_rdata_o, 32'h4433_2211);
      next();
    end

    // Simultaneous IF and MEM requests: MEM byte load first, then the fetch
    bus.mem_len_i = 2'd0; bus.mem_addr_i = 32'h3000; bus.if_addr_i = 32'h1000;
    for (int c = 0; c <= 13; c++) begin
      bus.mem_req_i = (c <= 3);
      bus.if_req_i  = (c <= 10);
      @(negedge clk);
      ea = (c == 1) ? 32'h3000 : (c >= 5 && c <= 8) ? 32'h1000 + 32'(c - 5) : 32'h0;
      check($sformatf("arb ram_a c%0d", c), bus.ram_a_o, ea);
      check($sformatf("arb mem_done c%0d", c), 32'(bus.mem_done_o), 32'(c == 3));
      check($sformatf("arb if_done c%0d", c), 32'(bus.if_done_o), 32'(c == 10));
      check($sformatf("arb if_stall c%0d", c), 32'(bus.if_stall_req_o), 32'(c <= 9));
      if (c == 3)  check("arb mem_rdata", bus.mem_rdata_o, 32'h0000_0034);
      if (c == 10) check("arb if_data", bus.if_data_o, 32'h0000_0513);
      next();
    end

    // rdy low for three cycles after the second fetch byte is issued
    bus.if_addr_i = 32'h1000;
    for (int c = 0; c <= 11; c++) begin
      bus.if_req_i = (c <= 10);
      bus.rdy      = !(c >= 3 && c <= 5);
      @(negedge clk);
      case (c)
        1:       ea = 32'h1000;
        2, 6:    ea = 32'h1001;
        7:       ea = 32'h1002;
        8:       ea = 32'h1003;
        default: ea = 32'h0;
      endcase
      check($sformatf("rdy ram_a c%0d", c), bus.ram_a_o, ea);
      check($sformatf("rdy ram_wr c%0d", c), 32'(bus.ram_wr_o), 32'h0);
      check($sformatf("rdy if_done c%0d", c), 32'(bus.if_done_o), 32'(c == 10));
      if (c == 10) check("rdy if_data", bus.if_data_o, 32'h0000_0513);
      next();
    end
    bus.rdy = 1'b1;

    // Reset in cycle 2 of a store, then a normal fetch
    w0 = wr_count;
    bus.mem_we_i = 1'b1; bus.mem_len_i = 2'd3;
    bus.mem_addr_i = 32'h2000; bus.mem_wdata_i = 32'hCAFE_F00D;
    for (int c = 0; c <= 4; c++) begin
      bus.mem_req_i = (c <= 2);
      rst           = (c == 2);
      @(negedge clk);
      check($sformatf("rst2 ram_wr c%0d", c), 32'(bus.ram_wr_o), 32'(c == 1 || c == 2));
      if (c >= 3) begin
        check($sformatf("rst2 ram_a c%0d", c), bus.ram_a_o, 32'h0);
        check($sformatf("rst2 ram_dout c%0d", c), 32'(bus.ram_dout_o), 32'h0);
        check($sformatf("rst2 mem_done c%0d", c), 32'(bus.mem_done_o), 32'h0);
        check($sformatf("rst2 mem_rdata c%0d", c), bus.mem_rdata_o, 32'h0);
        check($sformatf("rst2 if_data c%0d", c), bus.if_data_o, 32'h0);
      end
      next();
    end
    check("rst2 write count", 32'(wr_count - w0), 32'd2);
    bus.mem_we_i = 1'b0;
    run_fetch("refetch");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
